// File: rtl/demux_dispatch_pkg.sv
// rtl/demux_dispatch_pkg.sv - shared types and constants for the dispatch controller
package demux_dispatch_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    MODE_DIRECTED = 2'b00,
    MODE_RR       = 2'b01,
    MODE_BCAST    = 2'b10,
    MODE_RSVD     = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_DELIVER = 1'b1
  } state_e;

endpackage

// File: rtl/demux_n_way16.sv
// rtl/demux_n_way16.sv - 16-bit one-of-N / all-of-N data steering
// Ports:
//   in_data  : word to steer
//   sel      : target way when bcast is low
//   bcast    : drive the word onto every way
//   out_data : per-way data, zero on ways not selected
module demux_n_way16
  import demux_dispatch_pkg::*;
#(
  parameter int  WAYS      = 4,
  localparam int SEL_WIDTH = $clog2(WAYS)
) (
  input  logic [DATA_W-1:0]            in_data,
  input  logic [SEL_WIDTH-1:0]         sel,
  input  logic                         bcast,
  output logic [WAYS-1:0][DATA_W-1:0]  out_data
);

  always_comb begin
    out_data = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (bcast || (sel == SEL_WIDTH'(i))) begin
        out_data[i] = in_data;
      end
    end
  end

endmodule

// File: rtl/demux_dispatch16.sv
// rtl/demux_dispatch16.sv - word dispatcher: directed, round-robin or broadcast delivery
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : producer handshake; in_data word, in_dest target, in_mode routing mode
//   out_data/out_valid   : per-way word and valid
//   out_ready            : per-way consumer ready
//   busy                 : a word is held and being delivered
//   err                  : one-cycle pulse after a rejected word
//   sent_count           : per-way completed delivery counters (wrapping)
module demux_dispatch16
  import demux_dispatch_pkg::*;
#(
  parameter int  WAYS      = 4,
  parameter int  COUNT_W   = 8,
  localparam int SEL_WIDTH = $clog2(WAYS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  input  logic [SEL_WIDTH-1:0]          in_dest,
  input  logic [1:0]                    in_mode,
  output logic [WAYS-1:0][DATA_W-1:0]   out_data,
  output logic [WAYS-1:0]               out_valid,
  input  logic [WAYS-1:0]               out_ready,
  output logic                          busy,
  output logic                          err,
  output logic [WAYS-1:0][COUNT_W-1:0]  sent_count
);

  localparam logic [WAYS-1:0]      ONE_HOT0 = WAYS'(1);
  localparam logic [SEL_WIDTH:0]   WAYS_W   = (SEL_WIDTH+1)'(WAYS);
  localparam logic [SEL_WIDTH-1:0] RR_LAST  = SEL_WIDTH'(WAYS - 1);

  state_e                     state, state_nxt;
  logic [WAYS-1:0]            pending, pending_nxt, done, accept_mask;
  logic [DATA_W-1:0]          hold_data;
  logic [SEL_WIDTH-1:0]       hold_sel, rr_ptr;
  logic                       hold_bcast;
  logic                       err_q;
  logic [WAYS-1:0][DATA_W-1:0] steer_data;

  mode_e mode;
  logic  dest_bad, reject, take, drop;

  assign mode     = mode_e'(in_mode);
  // Destinations past the last way are only reachable when WAYS is not a power of 2.
  assign dest_bad = ({1'b0, in_dest} >= WAYS_W);
  assign reject   = (mode == MODE_RSVD) || ((mode == MODE_DIRECTED) && dest_bad);
  assign take     = in_valid && in_ready && !reject;
  assign drop     = in_valid && in_ready && reject;

  assign in_ready  = (state == ST_IDLE);
  assign busy      = (state == ST_DELIVER);
  assign err       = err_q;
  assign out_valid = pending;
  // pending is all-zero in IDLE, so this is only live while delivering.
  assign done      = pending & out_ready;

  always_comb begin
    accept_mask = '0;
    case (mode)
      MODE_DIRECTED: accept_mask = ONE_HOT0 << in_dest;
      MODE_RR:       accept_mask = ONE_HOT0 << rr_ptr;
      MODE_BCAST:    accept_mask = '1;
      default:       accept_mask = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    case (state)
      ST_IDLE: begin
        if (take) begin
          state_nxt   = ST_DELIVER;
          pending_nxt = accept_mask;
        end
      end
      ST_DELIVER: begin
        pending_nxt = pending & ~done;
        if (pending_nxt == '0) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= '0;
      hold_data  <= '0;
      hold_sel   <= '0;
      hold_bcast <= 1'b0;
      rr_ptr     <= '0;
      err_q      <= 1'b0;
      sent_count <= '0;
    end else begin
      pending <= pending_nxt;
      err_q   <= drop;
      if (take) begin
        hold_data  <= in_data;
        hold_bcast <= (mode == MODE_BCAST);
        hold_sel   <= (mode == MODE_RR) ? rr_ptr : in_dest;
        if (mode == MODE_RR) begin
          rr_ptr <= (rr_ptr == RR_LAST) ? '0 : rr_ptr + SEL_WIDTH'(1);
        end
      end
      for (int i = 0; i < WAYS; i++) begin
        if (done[i]) begin
          sent_count[i] <= sent_count[i] + COUNT_W'(1);
        end
      end
    end
  end

  demux_n_way16 #(.WAYS(WAYS)) u_steer (
    .in_data  (hold_data),
    .sel      (hold_sel),
    .bcast    (hold_bcast),
    .out_data (steer_data)
  );

  // Steering picks the way; pending hides ways that have already completed.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (pending[i]) begin
        out_data[i] = steer_data[i];
      end
    end
  end

endmodule
